// File: rtl/a23_loader_pkg.sv
// Shared constants for the a23 init loader: region codes, run-state encoding
// and the run-cycle counter width.
package a23_loader_pkg;

  localparam logic [1:0] REG_CODE = 2'd0;
  localparam logic [1:0] REG_G    = 2'd1;
  localparam logic [1:0] REG_E    = 2'd2;
  localparam logic [1:0] REG_RSVD = 2'd3;

  typedef enum logic [1:0] {
    StLoad = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } loader_state_e;

  localparam int unsigned         CntWidth = 32;
  localparam logic [CntWidth-1:0] CntSat   = {CntWidth{1'b1}};

endpackage

// File: rtl/a23_init_region_buf.sv
// One init-image region: flat SIZE-word register array filled in order by a
// write pointer. Writes past the last word are dropped and flagged.
module a23_init_region_buf #(
  parameter int unsigned SIZE = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr_i,
  input  logic                we_i,
  input  logic [31:0]         wdata_i,
  output logic [SIZE*32-1:0]  data_o,
  output logic                ovf_o
);

  localparam int unsigned PtrW = $clog2(SIZE + 1);

  logic [SIZE*32-1:0] mem_q, mem_d;
  logic [PtrW-1:0]    ptr_q, ptr_d;
  logic               full;

  assign full   = (ptr_q == PtrW'(SIZE));
  assign ovf_o  = we_i & full;
  assign data_o = mem_q;

  always_comb begin
    mem_d = mem_q;
    ptr_d = ptr_q;
    if (clr_i) begin
      mem_d = '0;
      ptr_d = '0;
    end else if (we_i && !full) begin
      for (int i = 0; i < SIZE; i++) begin
        if (ptr_q == PtrW'(i)) mem_d[32*i +: 32] = wdata_i;
      end
      ptr_d = ptr_q + PtrW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q <= '0;
      ptr_q <= '0;
    end else begin
      mem_q <= mem_d;
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/a23_init_loader.sv
// Streams program/garbler/evaluator words into flat init buses, holds the core
// in reset while loading, then times the run until terminate.
module a23_init_loader
  import a23_loader_pkg::*;
#(
  parameter int unsigned CODE_MEM_SIZE = 64,
  parameter int unsigned G_MEM_SIZE    = 64,
  parameter int unsigned E_MEM_SIZE    = 64
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic [31:0]                s_data,
  input  logic [1:0]                 s_region,
  input  logic                       start,
  input  logic                       clear,
  input  logic                       terminate,
  output logic                       core_rst,
  output logic [CODE_MEM_SIZE*32-1:0] p_init,
  output logic [G_MEM_SIZE*32-1:0]    g_init,
  output logic [E_MEM_SIZE*32-1:0]    e_init,
  output logic                       done,
  output logic                       err,
  output logic [CntWidth-1:0]        cycle_count
);

  loader_state_e       state_q, state_d;
  logic [CntWidth-1:0] cnt_q, cnt_d;
  logic                err_q, err_d;
  logic                done_q, done_d;
  logic                core_rst_q, core_rst_d;

  logic hs, we_code, we_g, we_e;
  logic ovf_code, ovf_g, ovf_e;

  assign s_ready = (state_q == StLoad);
  // A beat in the clear cycle is discarded.
  assign hs      = s_valid & s_ready & ~clear;
  assign we_code = hs & (s_region == REG_CODE);
  assign we_g    = hs & (s_region == REG_G);
  assign we_e    = hs & (s_region == REG_E);

  a23_init_region_buf #(.SIZE(CODE_MEM_SIZE)) u_code_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (clear),
    .we_i    (we_code),
    .wdata_i (s_data),
    .data_o  (p_init),
    .ovf_o   (ovf_code)
  );

  a23_init_region_buf #(.SIZE(G_MEM_SIZE)) u_g_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (clear),
    .we_i    (we_g),
    .wdata_i (s_data),
    .data_o  (g_init),
    .ovf_o   (ovf_g)
  );

  a23_init_region_buf #(.SIZE(E_MEM_SIZE)) u_e_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (clear),
    .we_i    (we_e),
    .wdata_i (s_data),
    .data_o  (e_init),
    .ovf_o   (ovf_e)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    if (clear) begin
      state_d = StLoad;
      cnt_d   = '0;
      err_d   = 1'b0;
    end else begin
      unique case (state_q)
        StLoad: begin
          if (hs && ((s_region == REG_RSVD) || ovf_code || ovf_g || ovf_e)) err_d = 1'b1;
          if (start) begin
            state_d = StRun;
            cnt_d   = '0;
          end
        end
        StRun: begin
          if (terminate) begin
            state_d = StDone;
          end else if (cnt_q != CntSat) begin
            cnt_d = cnt_q + CntWidth'(1);
          end
        end
        StDone: ;
        default: state_d = StLoad;
      endcase
    end
    core_rst_d = (state_d == StLoad);
    done_d     = (state_d == StDone);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StLoad;
      cnt_q      <= '0;
      err_q      <= 1'b0;
      done_q     <= 1'b0;
      core_rst_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      done_q     <= done_d;
      core_rst_q <= core_rst_d;
    end
  end

  assign core_rst    = core_rst_q;
  assign done        = done_q;
  assign err         = err_q;
  assign cycle_count = cnt_q;

endmodule

// File: tb/tb_a23_init_loader.sv
// Directed bench for a23_init_loader: a per-cycle reference model plus
// hand-computed spot checks.
module tb_a23_init_loader;

  localparam int N = 64;

  logic              clk, rst_n;
  logic              s_valid, s_ready, start, clear, terminate;
  logic [31:0]       s_data;
  logic [1:0]        s_region;
  logic              core_rst, done, err;
  logic [N*32-1:0]   p_init, g_init, e_init;
  logic [31:0]       cycle_count;

  int n_checks = 0;
  int n_errors = 0;

  a23_init_loader #(
    .CODE_MEM_SIZE (N),
    .G_MEM_SIZE    (N),
    .E_MEM_SIZE    (N)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_data      (s_data),
    .s_region    (s_region),
    .start       (start),
    .clear       (clear),
    .terminate   (terminate),
    .core_rst    (core_rst),
    .p_init      (p_init),
    .g_init      (g_init),
    .e_init      (e_init),
    .done        (done),
    .err         (err),
    .cycle_count (cycle_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: phase 0 = loading, 1 = running, 2 = finished.
  logic [31:0] m [3][N];
  int          ptr [3];
  int          phase;
  logic        m_err;
  logic [31:0] m_cnt;

  task automatic model_reset();
    for (int r = 0; r < 3; r++) begin
      ptr[r] = 0;
      for (int i = 0; i < N; i++) m[r][i] = 32'h0;
    end
    phase = 0;
    m_err = 1'b0;
    m_cnt = 32'h0;
  endtask

  task automatic model_step();
    int r;
    if (clear) begin
      model_reset();
    end else if (phase == 0) begin
      if (s_valid) begin
        r = int'(s_region);
        if (r == 3 || ptr[r] == N) m_err = 1'b1;
        else begin
          m[r][ptr[r]] = s_data;
          ptr[r]++;
        end
      end
      if (start) begin
        phase = 1;
        m_cnt = 32'h0;
      end
    end else if (phase == 1) begin
      if (terminate) phase = 2;
      else if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_bus(input string nm, input logic [N*32-1:0] act, input int r);
    int bad;
    bad = -1;
    n_checks++;
    for (int i = 0; i < N; i++) begin
      if (bad < 0 && act[32*i +: 32] !== m[r][i]) bad = i;
    end
    if (bad >= 0) begin
      n_errors++;
      $display("FAIL %s word %0d: got %h want %h at %0t", nm, bad, act[32*bad +: 32],
               m[r][bad], $time);
    end
  endtask

  // Per-cycle compare: advance the model on the edge, check mid-cycle.
  initial begin
    model_reset();
    forever begin
      @(posedge clk);
      if (!rst_n) model_reset();
      else model_step();
      #4;
      if (!rst_n) model_reset();
      chk("s_ready", {31'b0, s_ready}, {31'b0, phase == 0});
      chk("core_rst", {31'b0, core_rst}, {31'b0, phase == 0});
      chk("done", {31'b0, done}, {31'b0, phase == 2});
      chk("err", {31'b0, err}, {31'b0, m_err});
      chk("cycle_count", cycle_count, m_cnt);
      chk_bus("p_init", p_init, 0);
      chk_bus("g_init", g_init, 1);
      chk_bus("e_init", e_init, 2);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [1:0] r, input logic [31:0] d);
    s_valid = 1'b1;
    s_region = r;
    s_data = d;
    tick(1);
    s_valid = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
  endtask

  initial begin
    rst_n = 1'b1; s_valid = 1'b0; s_data = '0; s_region = '0;
    start = 1'b0; clear = 1'b0; terminate = 1'b0;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rst core_rst", {31'b0, core_rst}, 32'd1);
    chk("rst s_ready", {31'b0, s_ready}, 32'd1);
    chk("rst err", {31'b0, err}, 32'd0);
    chk("rst count", cycle_count, 32'd0);

    // Full code region plus a few g/e words.
    for (int i = 0; i < N; i++) beat(2'd0, 32'(i));
    beat(2'd1, 32'h5);
    beat(2'd1, 32'h7);
    beat(2'd2, 32'h9);
    chk("p63", p_init[63*32 +: 32], 32'h3F);
    chk("p0", p_init[31:0], 32'h0);
    chk("g0", g_init[31:0], 32'h5);
    chk("g1", g_init[63:32], 32'h7);
    chk("g2", g_init[95:64], 32'h0);
    chk("e0", e_init[31:0], 32'h9);
    chk("load err", {31'b0, err}, 32'd0);

    // Interleaved regions.
    pulse_clear();
    chk("clr p63", p_init[63*32 +: 32], 32'h0);
    beat(2'd1, 32'hA);
    beat(2'd2, 32'hB);
    beat(2'd1, 32'hC);
    chk("il g0", g_init[31:0], 32'hA);
    chk("il g1", g_init[63:32], 32'hC);
    chk("il e0", e_init[31:0], 32'hB);

    // Overflow and reserved region.
    pulse_clear();
    for (int i = 0; i < N; i++) beat(2'd0, 32'h100 + 32'(i));
    chk("ovf ready", {31'b0, s_ready}, 32'd1);
    beat(2'd0, 32'hDEAD);
    chk("ovf p63", p_init[63*32 +: 32], 32'h13F);
    chk("ovf err", {31'b0, err}, 32'd1);
    pulse_clear();
    chk("clr err", {31'b0, err}, 32'd0);
    beat(2'd3, 32'h1234);
    chk("rsvd err", {31'b0, err}, 32'd1);
    chk("rsvd p0", p_init[31:0], 32'h0);

    // start with a beat in the same cycle, terminate sampled 11 edges later.
    pulse_clear();
    s_valid = 1'b1; s_region = 2'd0; s_data = 32'h77; start = 1'b1;
    tick(1);
    s_valid = 1'b0; start = 1'b0;
    chk("run core_rst", {31'b0, core_rst}, 32'd0);
    chk("run s_ready", {31'b0, s_ready}, 32'd0);
    chk("run p0", p_init[31:0], 32'h77);
    chk("run count0", cycle_count, 32'd0);
    tick(2);
    start = 1'b1; s_valid = 1'b1; s_data = 32'hBAD;
    tick(1);
    start = 1'b0; s_valid = 1'b0;
    tick(7);
    chk("pre-term count", cycle_count, 32'd10);
    chk("pre-term done", {31'b0, done}, 32'd0);
    terminate = 1'b1;
    tick(1);
    chk("term done", {31'b0, done}, 32'd1);
    chk("term count", cycle_count, 32'd10);
    tick(3);
    chk("hold count", cycle_count, 32'd10);
    chk("hold core_rst", {31'b0, core_rst}, 32'd0);
    chk("run p1", p_init[63:32], 32'h0);
    terminate = 1'b0;

    // clear after 5 run cycles.
    pulse_clear();
    chk("clr done", {31'b0, done}, 32'd0);
    beat(2'd0, 32'h55);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(5);
    chk("run5 count", cycle_count, 32'd5);
    pulse_clear();
    chk("clr2 core_rst", {31'b0, core_rst}, 32'd1);
    chk("clr2 count", cycle_count, 32'd0);
    chk("clr2 ready", {31'b0, s_ready}, 32'd1);
    chk("clr2 p0", p_init[31:0], 32'h0);

    // Beat in the clear cycle is dropped.
    s_valid = 1'b1; s_region = 2'd0; s_data = 32'h66; clear = 1'b1;
    tick(1);
    s_valid = 1'b0; clear = 1'b0;
    chk("clrbeat p0", p_init[31:0], 32'h0);
    beat(2'd0, 32'h44);
    chk("after clr p0", p_init[31:0], 32'h44);

    // Asynchronous reset mid-load.
    beat(2'd2, 32'h3);
    beat(2'd3, 32'h0);
    rst_n = 1'b0;
    #2;
    chk("arst err", {31'b0, err}, 32'd0);
    chk("arst p0", p_init[31:0], 32'h0);
    chk("arst e0", e_init[31:0], 32'h0);
    chk("arst core_rst", {31'b0, core_rst}, 32'd1);
    @(posedge clk);
    #1 rst_n = 1'b1;
    beat(2'd1, 32'h21);
    chk("post-rst g0", g_init[31:0], 32'h21);
    tick(3);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
